// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer for an external 1-bit ALU slice.
// Latches operands on start, walks the slice LSB first with a chained carry,
// runs a compare pass plus a set pass for SLT/SLTU, and returns the assembled
// result together with a one-cycle done pulse.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, op_i, a_i, b_i request handshake, opcode and operands
//   busy_o, done_o          status; done_o marks result/carry/ovf valid
//   result_o, carry_o, ovf_o
//   slice_*_o / slice_*_i   drive / return of the 1-bit ALU slice
module alu_serial_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         ovf_o,
    output logic         slice_a_o,
    output logic         slice_b_o,
    output logic         slice_c_o,
    output logic [3:0]   slice_sel_o,
    output logic         slice_inver_o,
    output logic         slice_set_o,
    input  logic         slice_res_i,
    input  logic         slice_c_i
);

    localparam int unsigned IW = $clog2(W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_SETP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [3:0]    op_q, op_d;
    logic          carry_q, carry_d;
    logic          less_q, less_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic last;
    logic first;
    logic arith;

    assign last  = (idx_q == IW'(W - 1));
    assign first = (idx_q == '0);
    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            less_q   <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            less_q   <= less_d;
            res_q    <= res_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        less_d   = less_q;
        res_d    = res_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (op_i == OP_SLT || op_i == OP_SLTU) ? S_CMP : S_RUN;
                end
            end
            S_RUN: begin
                carry_d      = slice_c_i;
                res_d[idx_q] = slice_res_i;
                if (last) begin
                    if (arith) begin
                        cout_d = slice_c_i;
                        // Overflow: carry into MSB differs from carry out of MSB
                        ovf_d  = slice_c_i ^ carry_q;
                    end
                    // Load result with the final bit so it is valid alongside done
                    result_d = res_d;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_CMP: begin
                carry_d = slice_c_i;
                if (last) begin
                    // Unsigned: borrow; signed: sign of A-B corrected by overflow
                    less_d  = (op_q == OP_SLTU) ? ~slice_c_i
                                                : (slice_res_i ^ (slice_c_i ^ carry_q));
                    idx_d   = '0;
                    state_d = S_SETP;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SETP: begin
                res_d[idx_q] = slice_res_i;
                if (last) begin
                    result_d = res_d;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Slice drive, decoded from the current state and bit index
    always_comb begin
        slice_a_o     = 1'b0;
        slice_b_o     = 1'b0;
        slice_c_o     = 1'b0;
        slice_sel_o   = 4'b0000;
        slice_inver_o = 1'b0;
        slice_set_o   = 1'b0;
        case (state_q)
            S_RUN: begin
                slice_a_o     = a_q[idx_q];
                slice_b_o     = b_q[idx_q];
                slice_sel_o   = op_q;
                slice_inver_o = (op_q == OP_SUB);
                slice_c_o     = first ? (op_q == OP_SUB) : carry_q;
            end
            S_CMP: begin
                slice_a_o     = a_q[idx_q];
                slice_b_o     = b_q[idx_q];
                slice_sel_o   = OP_SUB;
                slice_inver_o = 1'b1;
                slice_c_o     = first ? 1'b1 : carry_q;
            end
            S_SETP: begin
                slice_sel_o = OP_SLT;
                slice_set_o = first ? less_q : 1'b0;
            end
            default: ;
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign carry_o  = cout_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (W=8) with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, ovf;
    logic [W-1:0] result;
    logic         s_a, s_b, s_ci, s_inv, s_set, s_res, s_co, bb;
    logic [3:0]   s_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.W(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .busy_o(busy), .done_o(done), .result_o(result), .carry_o(carry), .ovf_o(ovf),
        .slice_a_o(s_a), .slice_b_o(s_b), .slice_c_o(s_ci), .slice_sel_o(s_sel),
        .slice_inver_o(s_inv), .slice_set_o(s_set),
        .slice_res_i(s_res), .slice_c_i(s_co)
    );

    // 1-bit ALU slice model
    always_comb begin
        bb    = s_b ^ s_inv;
        s_res = 1'b0;
        s_co  = 1'b0;
        case (s_sel)
            4'b0000, 4'b0101: begin
                s_res = s_a ^ bb ^ s_ci;
                s_co  = (s_a & bb) | (s_a & s_ci) | (bb & s_ci);
            end
            4'b0001: s_res = s_a & bb;
            4'b0010: s_res = s_a | bb;
            4'b0011: s_res = s_a ^ bb;
            4'b0110: s_res = s_set;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for done
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c, output logic v, output int lat);
        int cyc;
        r = '0; c = 1'b0; v = 1'b0; lat = -1;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'hF; a = ~x; b = ~y;
        cyc = 1;
        check("busy_cycle1", 32'(busy), 32'd1);
        while (cyc <= 40 && lat < 0) begin
            if (done) begin
                lat = cyc; r = result; c = carry; v = ovf;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         carry, ovf;
        int           lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [W-1:0] r;
        logic         c, v;
        int           lat;
        int           dcnt, dcyc;

        vecs[0]  = '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 9};
        vecs[1]  = '{4'b0101, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 9};
        vecs[2]  = '{4'b0011, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 9};
        vecs[3]  = '{4'b0001, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 9};
        vecs[4]  = '{4'b0010, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 9};
        vecs[5]  = '{4'b0110, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 17};
        vecs[6]  = '{4'b0100, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 17};
        vecs[7]  = '{4'b0110, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 17};
        vecs[8]  = '{4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 9};
        vecs[9]  = '{4'b0101, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 9};
        vecs[10] = '{4'b0100, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0, 17};
        vecs[11] = '{4'b0110, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 17};
        vecs[12] = '{4'b0111, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0, 9};
        vecs[13] = '{4'b0000, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 9};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry_ovf", 32'({carry, ovf}), 32'd0);
        check("rst_slice", 32'({s_a, s_b, s_ci, s_sel, s_inv, s_set}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_res", i), 32'(r), 32'(vecs[i].res));
            check($sformatf("v%0d_carry", i), 32'(c), 32'(vecs[i].carry));
            check($sformatf("v%0d_ovf", i), 32'(v), 32'(vecs[i].ovf));
        end

        // Start pulses while busy (cycle 3 and the done cycle 9) are ignored
        @(posedge clk); #1;
        start = 1'b1; op = 4'b0000; a = 8'h10; b = 8'h20;
        dcnt = 0; dcyc = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 3 || cyc == 9);
            a = 8'h01; b = 8'h01;
            if (done) begin dcnt++; dcyc = cyc; end
            if (cyc == 10) check("busy_low_c10", 32'(busy), 32'd0);
        end
        start = 1'b0;
        check("ignore_done_count", 32'(dcnt), 32'd1);
        check("ignore_done_cycle", 32'(dcyc), 32'd9);
        check("ignore_result", 32'(result), 32'h30);

        // Reset mid-SLT aborts without done, then a fresh ADD works
        @(posedge clk); #1;
        start = 1'b1; op = 4'b0110; a = 8'h80; b = 8'h01;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_outputs", 32'({done, carry, ovf, result}), 32'd0);
        check("abort_slice", 32'({s_a, s_b, s_ci, s_sel, s_inv, s_set}), 32'd0);
        dcnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        run_op(4'b0000, 8'h03, 8'h04, r, c, v, lat);
        check("post_abort_lat", 32'(lat), 32'd9);
        check("post_abort_res", 32'(r), 32'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
